// File: rtl/core101_bp_pkg.sv
// ----------------------------------------------------------------------------
// core101_bp_pkg
// Shared definitions for the branch predictor: direction-counter width and
// state encodings, the counter value written on allocation, and helpers that
// derive the index/tag field widths from the address width and table depth.
//
// Build option: define BRANCH_PREDICTOR_2BIT_EN for a 2-bit saturating
// counter; otherwise the counter is 1 bit holding the last resolved outcome.
// ----------------------------------------------------------------------------
package core101_bp_pkg;

`ifdef BRANCH_PREDICTOR_2BIT_EN
   localparam int CTR_W = 2;
   localparam logic [CTR_W-1:0] CTR_SNT   = 2'b00;  // strongly not-taken
   localparam logic [CTR_W-1:0] CTR_WNT   = 2'b01;  // weakly not-taken
   localparam logic [CTR_W-1:0] CTR_WT    = 2'b10;  // weakly taken
   localparam logic [CTR_W-1:0] CTR_ST    = 2'b11;  // strongly taken
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_WT;
`else
   localparam int CTR_W = 1;
   localparam logic [CTR_W-1:0] CTR_NT    = 1'b0;
   localparam logic [CTR_W-1:0] CTR_T     = 1'b1;
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_T;
`endif

   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

   // Valid field is a single bit per entry.
   localparam int VALID_W = 1;

   // Index field is pc[IDX_W+1:2] (word-aligned fetch).
   function automatic int bp_idx_w(input int entries);
      return $clog2(entries);
   endfunction

   // Tag field is everything above the index.
   function automatic int bp_tag_w(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// ----------------------------------------------------------------------------
// bp_sat_counter
// Next-state logic for one direction counter (purely combinational).
//   ctr_in   : current counter value
//   taken_in : resolved direction, 1 = taken
//   ctr_out  : updated counter value
// With BRANCH_PREDICTOR_2BIT_EN the counter saturates at 00 and 11; without
// it the counter simply records the resolved direction.
// ----------------------------------------------------------------------------
module bp_sat_counter
   import core101_bp_pkg::*;
(
   input  logic [CTR_W-1:0] ctr_in,
   input  logic             taken_in,
   output logic [CTR_W-1:0] ctr_out
);

`ifdef BRANCH_PREDICTOR_2BIT_EN
   always_comb begin
      ctr_out = ctr_in;
      if (taken_in && (ctr_in != CTR_ST)) begin
         ctr_out = ctr_in + CTR_ONE;
      end else if (!taken_in && (ctr_in != CTR_SNT)) begin
         ctr_out = ctr_in - CTR_ONE;
      end
   end
`else
   // Current value is irrelevant: the counter just records the outcome.
   logic unused_ctr_in;
   assign unused_ctr_in = ^ctr_in;
   assign ctr_out       = taken_in;
`endif

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a per-entry direction counter.
// Lookups are answered one cycle later through registered outputs; updates
// from execute train the counter, and taken branches allocate on a miss.
//
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   bp_lookup_valid_in/pc_in    fetch-side lookup request
//   bp_update_valid_in/pc_in/
//   bp_update_target_in/
//   bp_update_taken_in          resolved branch report from execute
//   bp_flush_in                 invalidate every entry
//   bp_pred_en_out              prediction valid (one cycle after lookup)
//   bp_pred_addr_out            predicted target, zero when not predicting
//
// Build option: BRANCH_PREDICTOR_2BIT_EN selects the 2-bit counter.
// ----------------------------------------------------------------------------
module branch_predictor
   import core101_bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            bp_lookup_valid_in,
   input  logic [XLEN-1:0] bp_lookup_pc_in,
   input  logic            bp_update_valid_in,
   input  logic [XLEN-1:0] bp_update_pc_in,
   input  logic [XLEN-1:0] bp_update_target_in,
   input  logic            bp_update_taken_in,
   input  logic            bp_flush_in,
   output logic            bp_pred_en_out,
   output logic [XLEN-1:0] bp_pred_addr_out
);

   localparam int IDX_W = bp_idx_w(ENTRIES);
   localparam int TAG_W = bp_tag_w(XLEN, ENTRIES);

   logic [ENTRIES*VALID_W-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]           tag_q    [ENTRIES];
   logic [TAG_W-1:0]           tag_d    [ENTRIES];
   logic [XLEN-1:0]            target_q [ENTRIES];
   logic [XLEN-1:0]            target_d [ENTRIES];
   logic [CTR_W-1:0]           ctr_q    [ENTRIES];
   logic [CTR_W-1:0]           ctr_d    [ENTRIES];

   logic            pred_en_q, pred_en_d;
   logic [XLEN-1:0] pred_addr_q, pred_addr_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;
   logic [CTR_W-1:0] ctr_step;

   assign lk_idx = bp_lookup_pc_in[IDX_W+1:2];
   assign lk_tag = bp_lookup_pc_in[XLEN-1:IDX_W+2];
   assign up_idx = bp_update_pc_in[IDX_W+1:2];
   assign up_tag = bp_update_pc_in[XLEN-1:IDX_W+2];

   // Byte offset within the instruction word carries no information.
   logic unused_pc_lo;
   assign unused_pc_lo = ^{bp_lookup_pc_in[1:0], bp_update_pc_in[1:0]};

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   bp_sat_counter u_sat_counter (
      .ctr_in   (ctr_q[up_idx]),
      .taken_in (bp_update_taken_in),
      .ctr_out  (ctr_step)
   );

   // Lookup reads the registered table, so a same-cycle update is not seen
   // (read-before-write). A flush in the lookup cycle suppresses the answer.
   always_comb begin
      pred_en_d   = 1'b0;
      pred_addr_d = '0;
      if (bp_lookup_valid_in && !bp_flush_in && valid_q[lk_idx] &&
          (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][CTR_W-1]) begin
         pred_en_d   = 1'b1;
         pred_addr_d = target_q[lk_idx];
      end
   end

   // Table update: flush wins over any training in the same cycle.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (bp_flush_in) begin
         valid_d = '0;
      end else if (bp_update_valid_in) begin
         if (up_hit) begin
            ctr_d[up_idx] = ctr_step;
            if (bp_update_taken_in) begin
               target_d[up_idx] = bp_update_target_in;
            end
         end else if (bp_update_taken_in) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = bp_update_target_in;
            ctr_d[up_idx]    = CTR_ALLOC;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q     <= '0;
         pred_en_q   <= 1'b0;
         pred_addr_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         pred_en_q   <= pred_en_d;
         pred_addr_q <= pred_addr_d;
         ctr_q       <= ctr_d;
      end
   end

   // Tag and target are only meaningful behind a valid bit; no reset needed.
   always_ff @(posedge clk_in) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign bp_pred_en_out   = pred_en_q;
   assign bp_pred_addr_out = pred_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor (XLEN=32, ENTRIES=16). Every cycle
// the expected registered output is pushed when the inputs are driven and
// popped after the next rising edge. Expectations that differ between the
// 1-bit and 2-bit counter builds are selected by BRANCH_PREDICTOR_2BIT_EN.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_2BIT_EN
   localparam bit TWO = 1'b1;
`else
   localparam bit TWO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lk_v;
   logic [31:0] lk_pc;
   logic        up_v;
   logic [31:0] up_pc;
   logic [31:0] up_tgt;
   logic        up_tk;
   logic        flush;
   logic        pred_en;
   logic [31:0] pred_addr;

   typedef struct {
      logic        en;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
      .clk_in              (clk),
      .rst_n_in            (rst_n),
      .bp_lookup_valid_in  (lk_v),
      .bp_lookup_pc_in     (lk_pc),
      .bp_update_valid_in  (up_v),
      .bp_update_pc_in     (up_pc),
      .bp_update_target_in (up_tgt),
      .bp_update_taken_in  (up_tk),
      .bp_flush_in         (flush),
      .bp_pred_en_out      (pred_en),
      .bp_pred_addr_out    (pred_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One clock: drive, push expectation, wait for the edge, pop and compare.
   task automatic step(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk,
                       input logic fl, input logic een,
                       input logic [31:0] eaddr, input string tag);
      exp_t e;
      lk_v = lv;  lk_pc = lpc;
      up_v = uv;  up_pc = upc; up_tgt = utgt; up_tk = utk;
      flush = fl;
      sb.push_back('{een, eaddr});
      @(posedge clk);
      #1;
      lk_v = 1'b0; up_v = 1'b0; flush = 1'b0;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_en"},   {31'd0, pred_en}, {31'd0, e.en});
         check({tag, "_addr"}, pred_addr, e.addr);
      end
   endtask

   task automatic lk(input logic [31:0] pc, input logic een,
                     input logic [31:0] eaddr, input string tag);
      step(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, een, eaddr, tag);
   endtask

   task automatic up(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input string tag);
      step(1'b0, 32'h0, 1'b1, pc, tgt, tk, 1'b0, 1'b0, 32'h0, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      lk_v = 1'b0; lk_pc = '0; up_v = 1'b0; up_pc = '0; up_tgt = '0;
      up_tk = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_en",   {31'd0, pred_en}, 32'd0);
      check("rst_addr", pred_addr, 32'd0);
      rst_n = 1'b1;

      lk(32'h100, 1'b0, 32'h0, "first_miss");

      up(32'h100, 32'h200, 1'b1, "alloc");
      lk(32'h100, 1'b1, 32'h200, "alloc_hit");

      // Not-taken update must not overwrite the target.
      up(32'h100, 32'hDEAD0000, 1'b0, "nt1");
      lk(32'h100, 1'b0, 32'h0, "after_nt");

      up(32'h100, 32'h200, 1'b1, "t1");
      up(32'h100, 32'h200, 1'b1, "t2");
      up(32'h100, 32'hDEAD0000, 1'b0, "nt2");
      lk(32'h100, TWO, TWO ? 32'h200 : 32'h0, "hyst");

      up(32'h100, 32'h200, 1'b1, "t3");
      lk(32'h140, 1'b0, 32'h0, "tag_miss");

      // Same-cycle lookup and update of the same entry sees old contents.
      step(1'b1, 32'h100, 1'b1, 32'h100, 32'hDEAD0000, 1'b0, 1'b0,
           1'b1, 32'h200, "rbw");
      lk(32'h100, TWO, TWO ? 32'h200 : 32'h0, "post_rbw");

      // Not-taken miss leaves the table alone.
      up(32'h140, 32'h300, 1'b0, "nt_miss");
      lk(32'h100, TWO, TWO ? 32'h200 : 32'h0, "nt_miss_keep");

      // Taken miss replaces the occupant.
      up(32'h140, 32'h300, 1'b1, "replace");
      lk(32'h100, 1'b0, 32'h0, "old_gone");
      lk(32'h140, 1'b1, 32'h300, "new_hit");

      // Upper saturation.
      up(32'h140, 32'h300, 1'b1, "sat_t1");
      up(32'h140, 32'h300, 1'b1, "sat_t2");
      up(32'h140, 32'h300, 1'b1, "sat_t3");
      up(32'h140, 32'h300, 1'b0, "sat_nt1");
      lk(32'h140, TWO, TWO ? 32'h300 : 32'h0, "sat_hi");
      up(32'h140, 32'h300, 1'b0, "sat_nt2");
      lk(32'h140, 1'b0, 32'h0, "sat_hi_down");

      // Lower saturation.
      up(32'h140, 32'h300, 1'b0, "sat_nt3");
      up(32'h140, 32'h300, 1'b0, "sat_nt4");
      up(32'h140, 32'h300, 1'b1, "sat_up");
      lk(32'h140, ~TWO, TWO ? 32'h0 : 32'h300, "sat_lo");

      // Distinct index coexists.
      up(32'h104, 32'h500, 1'b1, "alloc_idx1");
      lk(32'h104, 1'b1, 32'h500, "idx1_hit");
      up(32'h100, 32'h200, 1'b1, "realloc");
      lk(32'h100, 1'b1, 32'h200, "realloc_hit");

      // No lookup request -> no prediction.
      step(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "no_req");

      // Flush overrides a same-cycle update and suppresses the lookup.
      step(1'b1, 32'h100, 1'b1, 32'h180, 32'h280, 1'b1, 1'b1,
           1'b0, 32'h0, "flush_cyc");
      lk(32'h100, 1'b0, 32'h0, "flush_100");
      lk(32'h180, 1'b0, 32'h0, "flush_180");
      lk(32'h104, 1'b0, 32'h0, "flush_104");

      // Mid-stream asynchronous reset.
      up(32'h100, 32'h200, 1'b1, "pre_rst_alloc");
      lk(32'h100, 1'b1, 32'h200, "pre_rst_hit");
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_en",   {31'd0, pred_en}, 32'd0);
      check("async_rst_addr", pred_addr, 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_en", {31'd0, pred_en}, 32'd0);
      rst_n = 1'b1;
      lk(32'h100, 1'b0, 32'h0, "post_rst_miss");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning table depth; a power of two, at least 2.
REQ-003 SHALL have port clk_in  input  1  the one clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port bp_lookup_valid_in  input  1  lookup request this cycle.
REQ-006 SHALL have port bp_lookup_pc_in  input  XLEN  current fetch PC.
REQ-007 SHALL have port bp_update_valid_in  input  1  resolved branch report from execute.
REQ-008 SHALL have port bp_update_pc_in  input  XLEN  PC of the resolved branch.
REQ-009 SHALL have port bp_update_target_in  input  XLEN  resolved target address.
REQ-010 SHALL have port bp_update_taken_in  input  1  resolved direction; 1 = taken.
REQ-011 SHALL have port bp_flush_in  input  1  invalidate all entries.
REQ-012 SHALL have port bp_pred_en_out  output  1  prediction valid; drives the PC calculator's prediction enable.
REQ-013 SHALL have port bp_pred_addr_out  output  XLEN  predicted target; drives the PC calculator's prediction address.

Function
REQ-014 SHALL index the table with pc[IDX+1:2], where IDX = log2(ENTRIES).
REQ-015 SHALL use pc[XLEN-1:IDX+2] as the tag.
REQ-016 SHALL hold per entry: valid, tag, target (XLEN bits) and a direction counter.
REQ-017 SHALL register the lookup result with 1-cycle latency: a lookup in cycle N is answered in cycle N+1.
REQ-018 SHALL set bp_pred_en_out=1 in N+1 only if lookup_valid was 1, the entry is valid, the tag matches and the counter predicts taken; otherwise 0.
REQ-019 SHALL drive bp_pred_addr_out with the entry target when bp_pred_en_out=1, else all zeros.
REQ-020 On an update hit (valid and tag match), SHALL step the counter toward taken or not-taken, saturating at both ends, and SHALL overwrite the target only when taken=1.
REQ-021 On an update miss with taken=1, SHALL allocate the entry: valid=1, tag and target written, counter set to weakly-taken; the previous occupant is replaced.
REQ-022 On an update miss with taken=0, SHALL leave the table unchanged.
REQ-023 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents (read-before-write).
REQ-024 Flush SHALL clear all valid bits at the next edge; flush overrides an update in the same cycle; bp_pred_en_out SHALL be 0 in the cycle after a flush.

Reset
REQ-025 While rst_n_in=0, all valid bits, counters, bp_pred_en_out and bp_pred_addr_out SHALL be 0, including when asserted mid-operation.
REQ-026 The first lookup after rst_n_in rises SHALL miss.

Configuration
REQ-027 With macro BRANCH_PREDICTOR_2BIT_EN defined, the counter SHALL be 2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken = bit 1; allocate value 10.
REQ-028 Without BRANCH_PREDICTOR_2BIT_EN, the counter SHALL be 1 bit holding the last outcome; predict taken = bit; allocate value 1; a hit update writes the resolved direction.
REQ-029 Ports and latency SHALL be identical in both configurations.

Structure
REQ-030 The shared package core101_bp_pkg SHALL hold the counter-state constants, the counter width and the entry-field widths.
REQ-031 Counter next-state logic SHALL live in one sub-module, bp_sat_counter, which is configured by the macro.

Verification (ENTRIES=16, XLEN=32, 2-bit build unless noted)
REQ-032 Reset, then lookup 0x100 -> next cycle pred_en=0, addr=0x0.
REQ-033 Update pc=0x100 taken target=0x200, then lookup 0x100 -> next cycle pred_en=1, addr=0x200.
REQ-034 After REQ-033, update 0x100 not-taken, then lookup -> pred_en=0. Update taken twice, then not-taken once, then lookup -> pred_en=1 (counter at 10). 1-bit build, same sequence -> pred_en=0.
REQ-035 With 0x100 allocated, lookup 0x140 (same index, different tag) -> pred_en=0. Lookup 0x100 in the same cycle as an update of 0x100 not-taken -> old prediction (pred_en=1, 0x200).
REQ-036 Flush and update 0x180 taken in the same cycle, then lookup 0x100 and 0x180 -> both pred_en=0.
REQ-037 Drop rst_n_in mid-stream between clock edges -> outputs go 0 immediately; after release, lookup 0x100 -> pred_en=0.
